// File: rtl/sal_bank_ctrl.sv
// Per-bank DRAM controller: buffers one decoded request, tracks the open row,
// and requests ACT/PRE/RD/WR while enforcing bank-local timing.
module sal_bank_ctrl #(
    parameter int RA_WIDTH  = 14,
    parameter int CA_WIDTH  = 10,
    parameter int ID_WIDTH  = 4,
    parameter int LEN_WIDTH = 4,
    parameter int T_RCD     = 4,
    parameter int T_RP      = 4,
    parameter int T_RAS     = 12,
    parameter int T_RTP     = 2,
    parameter int T_WR      = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ID_WIDTH-1:0]  req_id,
    input  logic [RA_WIDTH-1:0]  req_ra,
    input  logic [CA_WIDTH-1:0]  req_ca,
    input  logic [LEN_WIDTH-1:0] req_len,
    input  logic                 req_wr,
    output logic                 cmd_act,
    output logic                 cmd_pre,
    output logic                 cmd_rd,
    output logic                 cmd_wr,
    input  logic                 cmd_gnt,
    output logic [RA_WIDTH-1:0]  cmd_ra,
    output logic [CA_WIDTH-1:0]  cmd_ca,
    output logic [ID_WIDTH-1:0]  cmd_id,
    output logic [LEN_WIDTH-1:0] cmd_len,
    input  logic                 ref_req,
    output logic                 ref_ack
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int T_MAX = max2(max2(max2(T_RCD, T_RP), max2(T_RAS, T_RTP)), T_WR);
    localparam int CNT_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    localparam logic [CNT_W-1:0] RCD_LD = CNT_W'(T_RCD - 1);
    localparam logic [CNT_W-1:0] RP_LD  = CNT_W'(T_RP - 1);
    localparam logic [CNT_W-1:0] RAS_LD = CNT_W'(T_RAS - 1);
    localparam logic [CNT_W-1:0] RTP_LD = CNT_W'(T_RTP - 1);
    localparam logic [CNT_W-1:0] WR_LD  = CNT_W'(T_WR - 1);

    typedef enum logic [1:0] {
        ST_CLOSED,
        ST_ACTIVATING,
        ST_OPEN,
        ST_PRECHARGING
    } state_t;

    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_ACT,
        CMD_PRE,
        CMD_RD,
        CMD_WR
    } cmd_t;

    function automatic logic [CNT_W-1:0] dec_sat(input logic [CNT_W-1:0] v);
        return (v == '0) ? '0 : v - 1'b1;
    endfunction

    state_t               state;
    cmd_t                 held_cmd;
    cmd_t                 cand_cmd;
    cmd_t                 cur_cmd;

    logic                 buf_valid;
    logic [ID_WIDTH-1:0]  buf_id;
    logic [RA_WIDTH-1:0]  buf_ra;
    logic [CA_WIDTH-1:0]  buf_ca;
    logic [LEN_WIDTH-1:0] buf_len;
    logic                 buf_wr;
    logic [RA_WIDTH-1:0]  open_row;

    logic [CNT_W-1:0]     rcd_cnt;
    logic [CNT_W-1:0]     ras_cnt;
    logic [CNT_W-1:0]     rtp_cnt;
    logic [CNT_W-1:0]     rp_cnt;

    logic                 row_hit;
    logic                 close_req;
    logic                 accept;
    logic                 granted;
    logic                 col_cmd;

    always_comb begin
        cand_cmd  = CMD_NONE;
        row_hit   = buf_valid && (buf_ra == open_row);
        close_req = ref_req || (buf_valid && !row_hit);
        case (state)
            ST_CLOSED: begin
                if (buf_valid && !ref_req) cand_cmd = CMD_ACT;
            end
            ST_OPEN: begin
                // Refresh outranks a pending hit; PRE waits for tRAS and tRTP/tWR.
                if (close_req) begin
                    if (ras_cnt == '0 && rtp_cnt == '0) cand_cmd = CMD_PRE;
                end else if (row_hit) begin
                    cand_cmd = buf_wr ? CMD_WR : CMD_RD;
                end
            end
            default: cand_cmd = CMD_NONE;
        endcase
        // A command left ungranted is replayed verbatim so it cannot change under the scheduler.
        cur_cmd = (held_cmd != CMD_NONE) ? held_cmd : cand_cmd;
    end

    assign accept    = req_valid && req_ready;
    assign granted   = cmd_gnt && (cur_cmd != CMD_NONE);
    assign req_ready = ~buf_valid;
    assign ref_ack   = (state == ST_CLOSED);

    assign cmd_act = (cur_cmd == CMD_ACT);
    assign cmd_pre = (cur_cmd == CMD_PRE);
    assign cmd_rd  = (cur_cmd == CMD_RD);
    assign cmd_wr  = (cur_cmd == CMD_WR);
    assign col_cmd = cmd_rd || cmd_wr;

    assign cmd_ra  = cmd_act ? buf_ra  : '0;
    assign cmd_ca  = col_cmd ? buf_ca  : '0;
    assign cmd_id  = col_cmd ? buf_id  : '0;
    assign cmd_len = col_cmd ? buf_len : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_CLOSED;
            held_cmd  <= CMD_NONE;
            buf_valid <= 1'b0;
            buf_id    <= '0;
            buf_ra    <= '0;
            buf_ca    <= '0;
            buf_len   <= '0;
            buf_wr    <= 1'b0;
            open_row  <= '0;
            rcd_cnt   <= '0;
            ras_cnt   <= '0;
            rtp_cnt   <= '0;
            rp_cnt    <= '0;
        end else begin
            held_cmd <= (cur_cmd != CMD_NONE && !cmd_gnt) ? cur_cmd : CMD_NONE;
            rcd_cnt  <= dec_sat(rcd_cnt);
            ras_cnt  <= dec_sat(ras_cnt);
            rtp_cnt  <= dec_sat(rtp_cnt);
            rp_cnt   <= dec_sat(rp_cnt);

            if (accept) begin
                buf_valid <= 1'b1;
                buf_id    <= req_id;
                buf_ra    <= req_ra;
                buf_ca    <= req_ca;
                buf_len   <= req_len;
                buf_wr    <= req_wr;
            end

            case (state)
                ST_CLOSED: begin
                    if (granted && cur_cmd == CMD_ACT) begin
                        open_row <= buf_ra;
                        rcd_cnt  <= RCD_LD;
                        ras_cnt  <= RAS_LD;
                        state    <= (T_RCD == 1) ? ST_OPEN : ST_ACTIVATING;
                    end
                end
                ST_ACTIVATING: begin
                    // Leave one edge early so the column command appears exactly T_RCD after ACT.
                    if (dec_sat(rcd_cnt) == '0) state <= ST_OPEN;
                end
                ST_OPEN: begin
                    if (granted) begin
                        case (cur_cmd)
                            CMD_RD: begin
                                rtp_cnt   <= (rtp_cnt > RTP_LD) ? rtp_cnt : RTP_LD;
                                buf_valid <= 1'b0;
                            end
                            CMD_WR: begin
                                rtp_cnt   <= (rtp_cnt > WR_LD) ? rtp_cnt : WR_LD;
                                buf_valid <= 1'b0;
                            end
                            CMD_PRE: begin
                                rp_cnt <= RP_LD;
                                state  <= (T_RP == 1) ? ST_CLOSED : ST_PRECHARGING;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_PRECHARGING: begin
                    if (dec_sat(rp_cnt) == '0) state <= ST_CLOSED;
                end
                default: state <= ST_CLOSED;
            endcase
        end
    end

endmodule

// File: tb/tb_sal_bank_ctrl.sv
// Scoreboard bench for sal_bank_ctrl: directed requests push expected granted
// commands with their cycle; a negedge monitor pops and compares each grant.
module tb_sal_bank_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_id;
    logic [13:0] req_ra;
    logic [9:0]  req_ca;
    logic [3:0]  req_len;
    logic        req_wr;
    logic        cmd_act, cmd_pre, cmd_rd, cmd_wr;
    logic        cmd_gnt;
    logic [13:0] cmd_ra;
    logic [9:0]  cmd_ca;
    logic [3:0]  cmd_id;
    logic [3:0]  cmd_len;
    logic        ref_req;
    logic        ref_ack;

    sal_bank_ctrl #(
        .RA_WIDTH(14), .CA_WIDTH(10), .ID_WIDTH(4), .LEN_WIDTH(4),
        .T_RCD(4), .T_RP(4), .T_RAS(12), .T_RTP(2), .T_WR(5)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_id(req_id), .req_ra(req_ra), .req_ca(req_ca), .req_len(req_len), .req_wr(req_wr),
        .cmd_act(cmd_act), .cmd_pre(cmd_pre), .cmd_rd(cmd_rd), .cmd_wr(cmd_wr),
        .cmd_gnt(cmd_gnt),
        .cmd_ra(cmd_ra), .cmd_ca(cmd_ca), .cmd_id(cmd_id), .cmd_len(cmd_len),
        .ref_req(ref_req), .ref_ack(ref_ack)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [1:0] K_ACT = 2'd0;
    localparam logic [1:0] K_PRE = 2'd1;
    localparam logic [1:0] K_RD  = 2'd2;
    localparam logic [1:0] K_WR  = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic [13:0] ra;
        logic [9:0]  ca;
        logic [3:0]  id;
        logic [3:0]  len;
        logic [31:0] at;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_ev;

    task automatic check(input string name, input logic [95:0] got, input logic [95:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic push(input logic [1:0] k, input int ra, input int ca, input int id,
                        input int len, input int at);
        ev_t e;
        e      = '0;
        e.kind = k;
        e.ra   = ra[13:0];
        e.ca   = ca[9:0];
        e.id   = id[3:0];
        e.len  = len[3:0];
        e.at   = at[31:0];
        exp_q.push_back(e);
    endtask

    // Monitor: every granted command must match the head of the expectation queue.
    always @(negedge clk) begin
        if (rst_n) begin
            check("cmd_onehot", 96'($countones({cmd_act, cmd_pre, cmd_rd, cmd_wr}) <= 1), 96'(1));
            if (cmd_gnt && (cmd_act || cmd_pre || cmd_rd || cmd_wr)) begin
                mon_ev    = '0;
                mon_ev.at = cyc[31:0];
                if (cmd_act) begin
                    mon_ev.kind = K_ACT;
                    mon_ev.ra   = cmd_ra;
                end else if (cmd_pre) begin
                    mon_ev.kind = K_PRE;
                end else begin
                    mon_ev.kind = cmd_wr ? K_WR : K_RD;
                    mon_ev.ca   = cmd_ca;
                    mon_ev.id   = cmd_id;
                    mon_ev.len  = cmd_len;
                end
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_cmd: got %h expected none (cycle %0d)", mon_ev, cyc);
                end else begin
                    check("cmd_event", 96'(mon_ev), 96'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic wait_cyc(input int k);
        while (cyc < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present a request at the current cycle; acc returns the cycle it was accepted in.
    task automatic send(input int id, input int ra, input int ca, input int len, input bit wr,
                        output int acc);
        int n;
        req_valid = 1'b1;
        req_id    = id[3:0];
        req_ra    = ra[13:0];
        req_ca    = ca[9:0];
        req_len   = len[3:0];
        req_wr    = wr;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL req_accept_timeout: got req_ready=0 expected 1 (cycle %0d)", cyc);
        end
        acc = cyc;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish by 200000");
        $fatal(1, "watchdog expired");
    end

    int a, b, c, d, e, f, h;
    int act1, act2, act3, act4;

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_id = '0; req_ra = '0; req_ca = '0;
        req_len = '0; req_wr = 1'b0; cmd_gnt = 1'b1; ref_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_cmds",    96'({cmd_act, cmd_pre, cmd_rd, cmd_wr}), 96'(0));
        check("rst_payload", 96'({cmd_ra, cmd_ca, cmd_id, cmd_len}), 96'(0));
        check("rst_ready",   96'(req_ready), 96'(1));
        check("rst_ref_ack", 96'(ref_ack), 96'(1));
        rst_n = 1'b1;
        repeat (2) begin @(posedge clk); #1; end

        // Single read: ACT the cycle after accept, RD four cycles after ACT.
        send(3, 'h12, 'h40, 3, 1'b0, a);
        act1 = a + 1;
        push(K_ACT, 'h12, 0, 0, 0, act1);
        push(K_RD, 0, 'h40, 3, 3, act1 + 4);
        wait_cyc(a + 5);
        @(negedge clk); check("ready_low_at_rd", 96'(req_ready), 96'(0));
        @(negedge clk); check("ready_after_rd",  96'(req_ready), 96'(1));
        @(posedge clk); #1;

        // Two row hits: RD each, no ACT and no PRE.
        send(4, 'h12, 'h41, 1, 1'b0, b);
        push(K_RD, 0, 'h41, 4, 1, b + 1);
        send(5, 'h12, 'h42, 0, 1'b0, b);
        push(K_RD, 0, 'h42, 5, 0, b + 1);

        // Row miss: PRE held off by tRAS (ACT+12), ACT +4 after PRE, RD +4 after ACT.
        send(6, 'h34, 'h10, 2, 1'b0, c);
        push(K_PRE, 0, 0, 0, 0, act1 + 12);
        act2 = act1 + 16;
        push(K_ACT, 'h34, 0, 0, 0, act2);
        push(K_RD, 0, 'h10, 6, 2, act2 + 4);
        wait_cyc(act2 + 5);

        // Open row 5 (tRAS of row 0x34 dominates the PRE).
        send(7, 'h5, 'h20, 1, 1'b0, d);
        push(K_PRE, 0, 0, 0, 0, act2 + 12);
        act3 = act2 + 16;
        push(K_ACT, 'h5, 0, 0, 0, act3);
        push(K_RD, 0, 'h20, 7, 1, act3 + 4);

        // Write hit after tRAS has elapsed, then a miss: PRE exactly 5 cycles after WR.
        wait_cyc(act3 + 14);
        send(8, 'h5, 'h30, 7, 1'b1, e);
        push(K_WR, 0, 'h30, 8, 7, e + 1);
        send(9, 'h6, 'h08, 2, 1'b0, d);
        push(K_PRE, 0, 0, 0, 0, e + 6);
        act4 = e + 10;
        push(K_ACT, 'h6, 0, 0, 0, act4);
        push(K_RD, 0, 'h08, 9, 2, act4 + 4);

        // Refresh with a row hit arriving: PRE instead of RD, ack after tRP, no ACT until release.
        wait_cyc(act4 + 14);
        f = cyc;
        ref_req = 1'b1;
        push(K_PRE, 0, 0, 0, 0, f);
        send(10, 'h6, 'h11, 5, 1'b0, d);
        wait_cyc(f + 3);
        @(negedge clk); check("ref_ack_precharging", 96'(ref_ack), 96'(0));
        @(negedge clk); check("ref_ack_closed",      96'(ref_ack), 96'(1));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); check("no_act_during_ref", 96'(cmd_act), 96'(0));
        end
        @(posedge clk); #1;
        wait_cyc(f + 10);
        ref_req = 1'b0;
        push(K_ACT, 'h6, 0, 0, 0, f + 10);
        push(K_RD, 0, 'h11, 10, 5, f + 14);

        // Close the bank, then stall an ACT with gnt low for 10 cycles.
        wait_cyc(f + 23);
        h = cyc;
        ref_req = 1'b1;
        push(K_PRE, 0, 0, 0, 0, h);
        wait_cyc(h + 5);
        ref_req = 1'b0;
        cmd_gnt = 1'b0;
        send(11, 'h77, 'h1, 1, 1'b0, d);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("act_held", 96'(cmd_act), 96'(1));
            check("ra_held",  96'(cmd_ra),  96'('h77));
        end
        @(posedge clk); #1;
        cmd_gnt = 1'b1;
        push(K_ACT, 'h77, 0, 0, 0, cyc);

        // Asynchronous reset in the middle of ACTIVATING.
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        check("arst_cmds",    96'({cmd_act, cmd_pre, cmd_rd, cmd_wr}), 96'(0));
        check("arst_payload", 96'({cmd_ra, cmd_ca, cmd_id, cmd_len}), 96'(0));
        check("arst_ready",   96'(req_ready), 96'(1));
        check("arst_ref_ack", 96'(ref_ack), 96'(1));
        #2 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("post_rst_ready",   96'(req_ready), 96'(1));
        check("post_rst_ref_ack", 96'(ref_ack), 96'(1));
        check("scoreboard_drained", 96'(exp_q.size()), 96'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sal_bank_ctrl.md
Name: sal_bank_ctrl

Overview:
- Per-bank DRAM controller that sits directly downstream of the address decoder.
- One instance per bank. It consumes a decoded request (id, row, column, length, direction) and tracks that bank's open row.
- It requests ACT, PRE, RD and WR commands from the downstream command scheduler and enforces bank-local timing (tRCD, tRP, tRAS, read-to-precharge, write recovery).
- It closes the row on a refresh request and acknowledges once the bank is precharged.

Parameters:
- RA_WIDTH, 14, row address width
- CA_WIDTH, 10, column address width
- ID_WIDTH, 4, AXI transaction id width
- LEN_WIDTH, 4, burst length field width
- T_RCD, 4, ACT-to-column-command cycles (≥1)
- T_RP, 4, PRE-to-ACT cycles (≥1)
- T_RAS, 12, ACT-to-PRE minimum cycles (≥1)
- T_RTP, 2, RD-to-PRE cycles (≥1)
- T_WR, 5, WR-to-PRE cycles (≥1)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  decoded request valid
- req_ready  out  1  request accepted when valid&ready
- req_id  in  ID_WIDTH  transaction id
- req_ra  in  RA_WIDTH  row address
- req_ca  in  CA_WIDTH  column address
- req_len  in  LEN_WIDTH  burst length
- req_wr  in  1  1=write, 0=read
- cmd_act  out  1  ACT request
- cmd_pre  out  1  PRE request
- cmd_rd  out  1  RD request
- cmd_wr  out  1  WR request
- cmd_gnt  in  1  scheduler grants the asserted command this cycle
- cmd_ra  out  RA_WIDTH  row for ACT
- cmd_ca  out  CA_WIDTH  column for RD/WR
- cmd_id  out  ID_WIDTH  id for RD/WR
- cmd_len  out  LEN_WIDTH  length for RD/WR
- ref_req  in  1  refresh pending; close the bank
- ref_ack  out  1  bank closed and idle

Behaviour:
- Clock and reset: one clock clk; reset rst_n is asynchronous, active-low.
- Reset (asserted at any time, including mid-command):
  - state CLOSED, request buffer empty, all counters 0, open row cleared.
  - cmd_* valids 0, payload outputs 0, req_ready=1, ref_ack=1.
- Request buffer: one entry.
  - req_ready = ~buf_valid.
  - On valid&ready, capture id/ra/ca/len/wr.
  - The buffer clears on the cycle its RD/WR is granted; req_ready rises the next cycle, so max throughput is one request per 2 cycles.
- Command outputs: at most one of cmd_act/pre/rd/wr is high in any cycle. Once raised, a command and its payload hold stable until cmd_gnt; cmd_gnt with no command asserted is ignored.
- States: CLOSED, ACTIVATING, OPEN, PRECHARGING.
- CLOSED:
  - ref_ack=1.
  - If buf_valid & ~ref_req, assert cmd_act with cmd_ra=buffered ra.
  - On gnt: open_row<=ra, rcd_cnt<=T_RCD-1, ras_cnt<=T_RAS-1, go to ACTIVATING.
  - ref_req held high blocks new ACTs.
- ACTIVATING:
  - Counters decrement by 1 per cycle, saturating at 0.
  - On rcd_cnt==0, go to OPEN.
  - Timing: ACT granted in cycle n, go to OPEN on the clock edge ending cycle n+T_RCD-1; the first RD/WR is asserted in cycle n+T_RCD.
- OPEN:
  - Row hit (buf_valid & ra==open_row) & ~ref_req: assert cmd_rd or cmd_wr per buffered wr, with ca/id/len.
    - On RD gnt: rtp_cnt<=max(rtp_cnt, T_RTP-1).
    - On WR gnt: rtp_cnt<=max(rtp_cnt, T_WR-1).
  - Precharge condition: row miss (buf_valid & ra≠open_row) or ref_req.
    - Assert cmd_pre only when ras_cnt==0 & rtp_cnt==0.
    - On gnt: rp_cnt<=T_RP-1, go to PRECHARGING.
  - ref_req has priority over a pending row hit.
  - Idle open bank with no ref_req stays OPEN indefinitely (open-page policy).
- PRECHARGING: on rp_cnt==0, go to CLOSED. Timing: PRE granted in cycle m, first ACT asserted in cycle m+T_RP.
- ref_ack: combinational, equals (state==CLOSED). It may be high while ref_req is low.
- Row-address comparison uses the full RA_WIDTH. Counters are wide enough to hold max(T_*)-1.

Test Plan:
- Reset, then one read to ra=0x12, ca=0x40, id=3, len=3, cmd_gnt tied 1. Required: ACT in cycle 1 after accept, RD 4 cycles after ACT with ca=0x40, id=3, len=3; req_ready high again the cycle after RD.
- Two reads to the same row 0x12 back to back. Required: a single ACT; the second RD is issued without PRE.
- Read row 0x12, then read row 0x34, gnt=1. Required: PRE no earlier than 12 cycles after ACT, ACT(0x34) exactly 4 cycles after PRE, then RD 4 cycles after that.
- Write row 0x5 followed by a miss to row 0x6, with T_RAS already elapsed. Required: PRE exactly 5 cycles after WR gnt.
- ref_req raised while OPEN with a row-hit request buffered. Required: PRE issued instead of RD, ref_ack=1 four cycles after PRE gnt, no ACT while ref_req=1; after ref_req drops, ACT then RD to the buffered row.
- cmd_gnt held 0 for 10 cycles during a pending ACT. Required: cmd_act and cmd_ra stable throughout. rst_n pulsed low mid-ACTIVATING: all cmd_* drop immediately, req_ready=1, ref_ack=1.
